// File: rtl/mod_counter.sv
// Up/down counter with runtime modulus, wrap/saturate bound, load, prescaled enable and sticky flags.
// One edge from tick/load to cnt; all outputs registered; no backpressure (accepts every cycle).
module mod_counter #(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] r_pre;
  logic          w_tick;

  // With PRESCALE=1 r_pre never leaves 0, so the tick degenerates to en.
  assign w_tick = en && (r_pre == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= RST_VAL;
      r_pre <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (clr_flags) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (load) begin
        cnt   <= load_val;
        r_pre <= '0;
      end else begin
        if (en) begin
          r_pre <= w_tick ? '0 : r_pre + PW'(1);
        end
        // Bound checks precede +1/-1 so the modulo-2^WIDTH arithmetic never leaks out.
        if (w_tick) begin
          if (up) begin
            if (cnt >= limit) begin
              cnt <= sat ? limit : '0;
              ovf <= 1'b1;
              tc  <= 1'b1;
            end else begin
              cnt <= cnt + WIDTH'(1);
            end
          end else begin
            if (cnt == '0) begin
              cnt <= sat ? '0 : limit;
              unf <= 1'b1;
              tc  <= 1'b1;
            end else begin
              cnt <= cnt - WIDTH'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: instance A (PRESCALE=1, RST_VAL=0) and B (PRESCALE=3, RST_VAL=7).
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load, sat, clr_flags;
  logic [7:0] load_val, limit;
  logic [7:0] a_cnt, b_cnt;
  logic       a_tc, a_ovf, a_unf, b_tc, b_ovf, b_unf;
  int         tests_run = 0;
  int         tests_failed = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(8), .RST_VAL(8'd0), .PRESCALE(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .limit(limit), .sat(sat), .clr_flags(clr_flags),
    .cnt(a_cnt), .tc(a_tc), .ovf(a_ovf), .unf(a_unf)
  );

  mod_counter #(.WIDTH(8), .RST_VAL(8'd7), .PRESCALE(3)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .limit(limit), .sat(sat), .clr_flags(clr_flags),
    .cnt(b_cnt), .tc(b_tc), .ovf(b_ovf), .unf(b_unf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; sat = 1'b0; clr_flags = 1'b0;
    load_val = 8'd0; limit = 8'd5;
    step(); step();
    tests_run++;
    if (a_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_a_cnt got %0d want 0", a_cnt); end
    tests_run++;
    if ({a_tc, a_ovf, a_unf} !== 3'b000) begin tests_failed++; $display("FAIL reset_a_flags got %b want 000", {a_tc, a_ovf, a_unf}); end
    tests_run++;
    if (b_cnt !== 8'd7) begin tests_failed++; $display("FAIL reset_b_cnt got %0d want 7", b_cnt); end
    tests_run++;
    if ({b_tc, b_ovf, b_unf} !== 3'b000) begin tests_failed++; $display("FAIL reset_b_flags got %b want 000", {b_tc, b_ovf, b_unf}); end
    rst = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [7:0] exp_cnt [7];
    exp_cnt = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
    limit = 8'd5; sat = 1'b0; up = 1'b1; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      tests_run++;
      if (a_cnt !== exp_cnt[i] || a_tc !== (i == 5)) begin
        tests_failed++;
        $display("FAIL up_wrap step %0d got cnt=%0d tc=%b want cnt=%0d tc=%b", i, a_cnt, a_tc, exp_cnt[i], (i == 5));
      end
    end
    tests_run++;
    if (a_ovf !== 1'b1) begin tests_failed++; $display("FAIL up_wrap_ovf got %b want 1", a_ovf); end
    en = 1'b0;
  endtask

  task automatic test_up_sat();
    logic [2:0] exp_tc;
    exp_tc = 3'b110;
    en = 1'b0; sat = 1'b1; up = 1'b1; limit = 8'd5; load = 1'b1; load_val = 8'd4; clr_flags = 1'b1;
    step();
    load = 1'b0; clr_flags = 1'b0;
    tests_run++;
    if (a_cnt !== 8'd4 || a_ovf !== 1'b0) begin tests_failed++; $display("FAIL sat_load got cnt=%0d ovf=%b want 4 0", a_cnt, a_ovf); end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (a_cnt !== 8'd5 || a_tc !== exp_tc[i]) begin
        tests_failed++;
        $display("FAIL up_sat step %0d got cnt=%0d tc=%b want cnt=5 tc=%b", i, a_cnt, a_tc, exp_tc[i]);
      end
    end
    tests_run++;
    if (a_ovf !== 1'b1) begin tests_failed++; $display("FAIL up_sat_ovf got %b want 1", a_ovf); end
    en = 1'b0; clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    tests_run++;
    if (a_ovf !== 1'b0 || a_cnt !== 8'd5 || a_tc !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_flags got ovf=%b cnt=%0d tc=%b want 0 5 0", a_ovf, a_cnt, a_tc);
    end
  endtask

  task automatic test_down();
    logic [7:0] exp_cnt [2][3];
    logic [2:0] exp_tc [2];
    exp_cnt = '{'{8'd0, 8'd9, 8'd8}, '{8'd0, 8'd0, 8'd0}};
    exp_tc  = '{3'b010, 3'b110};
    for (int m = 0; m < 2; m++) begin
      sat = (m == 1); limit = 8'd9; up = 1'b0; en = 1'b0;
      load = 1'b1; load_val = 8'd1; clr_flags = 1'b1;
      step();
      load = 1'b0; clr_flags = 1'b0;
      tests_run++;
      if (a_cnt !== 8'd1 || a_unf !== 1'b0) begin tests_failed++; $display("FAIL down_load mode %0d got cnt=%0d unf=%b want 1 0", m, a_cnt, a_unf); end
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step();
        tests_run++;
        if (a_cnt !== exp_cnt[m][i] || a_tc !== exp_tc[m][i] || a_unf !== (i > 0)) begin
          tests_failed++;
          $display("FAIL down mode %0d step %0d got cnt=%0d tc=%b unf=%b want cnt=%0d tc=%b unf=%b",
                   m, i, a_cnt, a_tc, a_unf, exp_cnt[m][i], exp_tc[m][i], (i > 0));
        end
      end
      en = 1'b0;
    end
  endtask

  task automatic test_prescale();
    logic [7:0] exp_cnt [8];
    logic [7:0] en_seq;
    exp_cnt = '{8'd7, 8'd7, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd9};
    en_seq  = 8'b1100_1111;
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0; limit = 8'd255; up = 1'b1; sat = 1'b0;
    for (int i = 0; i < 8; i++) begin
      en = en_seq[i];
      step();
      tests_run++;
      if (b_cnt !== exp_cnt[i]) begin
        tests_failed++;
        $display("FAIL prescale step %0d got cnt=%0d want %0d", i, b_cnt, exp_cnt[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_priority();
    limit = 8'd10; sat = 1'b0; up = 1'b1; en = 1'b1;
    load = 1'b1; load_val = 8'd200; clr_flags = 1'b1;
    step();
    load = 1'b0; clr_flags = 1'b0;
    tests_run++;
    if (a_cnt !== 8'd200 || a_tc !== 1'b0 || a_ovf !== 1'b0) begin
      tests_failed++; $display("FAIL load_over_tick got cnt=%0d tc=%b ovf=%b want 200 0 0", a_cnt, a_tc, a_ovf);
    end
    step();
    tests_run++;
    if (a_cnt !== 8'd0 || a_tc !== 1'b1 || a_ovf !== 1'b1) begin
      tests_failed++; $display("FAIL up_from_above got cnt=%0d tc=%b ovf=%b want 0 1 1", a_cnt, a_tc, a_ovf);
    end
    load = 1'b1;
    step();
    load = 1'b0; up = 1'b0;
    step();
    tests_run++;
    if (a_cnt !== 8'd199 || a_tc !== 1'b0) begin
      tests_failed++; $display("FAIL down_from_above got cnt=%0d tc=%b want 199 0", a_cnt, a_tc);
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    limit = 8'd0; up = 1'b1; sat = 1'b0; en = 1'b1;
    step();
    tests_run++;
    if (a_cnt !== 8'd0 || a_tc !== 1'b1 || a_ovf !== 1'b1) begin
      tests_failed++; $display("FAIL limit0_up got cnt=%0d tc=%b ovf=%b want 0 1 1", a_cnt, a_tc, a_ovf);
    end
    load = 1'b1; load_val = 8'd6; limit = 8'd255;
    step();
    load = 1'b0;
    step();
    tests_run++;
    if (a_cnt !== 8'd7 || a_ovf !== 1'b1 || b_cnt !== 8'd6) begin
      tests_failed++; $display("FAIL pre_reset got a_cnt=%0d a_ovf=%b b_cnt=%0d want 7 1 6", a_cnt, a_ovf, b_cnt);
    end
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0;
    tests_run++;
    if (a_cnt !== 8'd0 || {a_tc, a_ovf, a_unf} !== 3'b000 || b_cnt !== 8'd7) begin
      tests_failed++;
      $display("FAIL reset_mid got a_cnt=%0d flags=%b b_cnt=%0d want 0 000 7", a_cnt, {a_tc, a_ovf, a_unf}, b_cnt);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (b_cnt !== ((i == 2) ? 8'd8 : 8'd7)) begin
        tests_failed++; $display("FAIL phase_discard step %0d got %0d want %0d", i, b_cnt, (i == 2) ? 8 : 7);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_boundary_clr();
    limit = 8'd0; up = 1'b1; sat = 1'b0; en = 1'b1; clr_flags = 1'b1;
    load = 1'b1; load_val = 8'd0;
    step();
    load = 1'b0;
    step();
    tests_run++;
    if (a_ovf !== 1'b1 || a_tc !== 1'b1 || a_cnt !== 8'd0) begin
      tests_failed++; $display("FAIL ovf_beats_clr got ovf=%b tc=%b cnt=%0d want 1 1 0", a_ovf, a_tc, a_cnt);
    end
    up = 1'b0;
    step();
    tests_run++;
    if (a_unf !== 1'b1 || a_ovf !== 1'b0 || a_cnt !== 8'd0 || a_tc !== 1'b1) begin
      tests_failed++;
      $display("FAIL unf_beats_clr got unf=%b ovf=%b cnt=%0d tc=%b want 1 0 0 1", a_unf, a_ovf, a_cnt, a_tc);
    end
    clr_flags = 1'b0; en = 1'b0;
  endtask

  task automatic test_full_range();
    limit = 8'd255; up = 1'b1; sat = 1'b0; en = 1'b0; clr_flags = 1'b1;
    load = 1'b1; load_val = 8'd255;
    step();
    load = 1'b0; clr_flags = 1'b0; en = 1'b1;
    step();
    tests_run++;
    if (a_cnt !== 8'd0 || a_tc !== 1'b1 || a_ovf !== 1'b1) begin
      tests_failed++; $display("FAIL full_wrap_up got cnt=%0d tc=%b ovf=%b want 0 1 1", a_cnt, a_tc, a_ovf);
    end
    up = 1'b0;
    step();
    tests_run++;
    if (a_cnt !== 8'd255 || a_tc !== 1'b1 || a_unf !== 1'b1) begin
      tests_failed++; $display("FAIL full_wrap_down got cnt=%0d tc=%b unf=%b want 255 1 1", a_cnt, a_tc, a_unf);
    end
    step();
    tests_run++;
    if (a_cnt !== 8'd254 || a_tc !== 1'b0) begin
      tests_failed++; $display("FAIL full_down_step got cnt=%0d tc=%b want 254 0", a_cnt, a_tc);
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_up_sat();
    test_down();
    test_prescale();
    test_load_priority();
    test_reset_mid();
    test_boundary_clr();
    test_full_range();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
